// File: rtl/det1011_arb2_pkg.sv
// rtl/det1011_arb2_pkg.sv - shared types and helpers for the 1011 detector scheduler
// Contents: FSM state enum, detector context type, context reset value,
// saturating 16-bit add used by the optional per-channel hit counters.
package det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  typedef logic [1:0] ctx_t;

  localparam ctx_t CTX_RST = 2'b00;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/det1011_arb2_if.sv
// rtl/det1011_arb2_if.sv - request/result bundle for det1011_arb2
// Signals: req0/req1 valid, data, ready (per-channel word handshake);
// res_valid, res_ch, res_hits (one-cycle result pulse, no backpressure).
// Modports: master = requester/consumer side, slave = scheduler side.
interface det1011_arb2_if #(
  parameter int DATA_W = 8,
  parameter int HIT_W  = $clog2(DATA_W + 1)
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              res_valid;
  logic              res_ch;
  logic [HIT_W-1:0]  res_hits;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, res_valid, res_ch, res_hits
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, res_valid, res_ch, res_hits
  );
endinterface

// File: rtl/det1011_arb2_core.sv
// rtl/det1011_arb2_core.sv - one-bit step of the serial 1011 Mealy detector
// Ports: Clock, Reset (async, active-high); load/load_state restore a saved
// context (load wins over en); en shifts in x; y is the combinational hit,
// state is the 2-bit detector context to be saved back.
module det1011_core
  import det_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic en,
  input  logic load,
  input  ctx_t load_state,
  input  logic x,
  output logic y,
  output ctx_t state
);

  // state[0]: last bit was 1; state[1]: prefix "10" or "101" is pending
  assign y = state[1] & state[0] & x;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= CTX_RST;
    end else if (load) begin
      state <= load_state;
    end else if (en) begin
      state <= {(state[0] & ~x) | (state[1] & ~state[0] & x), x};
    end
  end

endmodule

// File: rtl/det1011_arb2.sv
// rtl/det1011_arb2.sv - two-channel round-robin scheduler sharing one 1011 detector
// Ports: Clock, Reset (async, active-high); bus (det1011_arb2_if.slave) carries
// both request handshakes and the result pulse; ctx_clr[i] clears channel i
// context while IDLE.
// Optional: DET_HITCNT_EN adds hit_cnt0/hit_cnt1 saturating per-channel totals.
module det1011_arb2
  import det_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int HIT_W  = $clog2(DATA_W + 1)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  det1011_arb2_if.slave         bus,
`ifdef DET_HITCNT_EN
  output logic [15:0]           hit_cnt0,
  output logic [15:0]           hit_cnt1,
`endif
  input  logic [1:0]            ctx_clr
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state, nstate;
  logic              last_grant, grant, win, any_valid;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bitcnt;
  logic [HIT_W-1:0]  acc, acc_next;
  ctx_t              ctx0, ctx1, core_state;
  logic              core_y;

  det1011_core u_core (
    .Clock      (Clock),
    .Reset      (Reset),
    .en         (state == SHIFT),
    .load       (state == LOAD),
    .load_state (grant ? ctx1 : ctx0),
    .x          (shreg[DATA_W-1]),
    .y          (core_y),
    .state      (core_state)
  );

  // On a tie the channel that did not win last time gets the grant
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign win       = bus.req1_valid & (~bus.req0_valid | ~last_grant);
  assign acc_next  = acc + HIT_W'(core_y);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate         = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: begin
        // Gated by Reset so ready is low while reset is held
        bus.req0_ready = ~Reset & bus.req0_valid & ~win;
        bus.req1_ready = ~Reset & bus.req1_valid & win;
        if (any_valid) nstate = LOAD;
      end
      LOAD:  nstate = SHIFT;
      SHIFT: if (bitcnt == '0) nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_grant    <= 1'b1;
      grant         <= 1'b0;
      shreg         <= '0;
      bitcnt        <= '0;
      acc           <= '0;
      ctx0          <= CTX_RST;
      ctx1          <= CTX_RST;
      bus.res_valid <= 1'b0;
      bus.res_ch    <= 1'b0;
      bus.res_hits  <= '0;
`ifdef DET_HITCNT_EN
      hit_cnt0      <= '0;
      hit_cnt1      <= '0;
`endif
    end else begin
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ctx_clr[0]) ctx0 <= CTX_RST;
          if (ctx_clr[1]) ctx1 <= CTX_RST;
`ifdef DET_HITCNT_EN
          if (ctx_clr[0]) hit_cnt0 <= '0;
          if (ctx_clr[1]) hit_cnt1 <= '0;
`endif
          if (any_valid) begin
            grant      <= win;
            last_grant <= win;
            shreg      <= win ? bus.req1_data : bus.req0_data;
          end
        end
        LOAD: begin
          bitcnt <= CNT_W'(DATA_W - 1);
          acc    <= '0;
        end
        SHIFT: begin
          shreg  <= shreg << 1;
          acc    <= acc_next;
          bitcnt <= bitcnt - CNT_W'(1);
          // Result registers are loaded on the last shift so they are live in DONE
          if (bitcnt == '0) begin
            bus.res_valid <= 1'b1;
            bus.res_ch    <= grant;
            bus.res_hits  <= acc_next;
          end
        end
        DONE: begin
          if (grant) ctx1 <= core_state;
          else       ctx0 <= core_state;
`ifdef DET_HITCNT_EN
          if (grant) hit_cnt1 <= sat_add16(hit_cnt1, 16'(bus.res_hits));
          else       hit_cnt0 <= sat_add16(hit_cnt0, 16'(bus.res_hits));
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_det1011_arb2.sv
// tb/tb_det1011_arb2.sv - scoreboard bench for det1011_arb2
module tb_det1011_arb2;

  localparam int DW = 8;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] ctx_clr = 2'b00;
`ifdef DET_HITCNT_EN
  logic [15:0] hit_cnt0, hit_cnt1;
`endif

  det1011_arb2_if #(.DATA_W(DW)) bus ();

  det1011_arb2 #(.DATA_W(DW)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .bus     (bus),
`ifdef DET_HITCNT_EN
    .hit_cnt0(hit_cnt0),
    .hit_cnt1(hit_cnt1),
`endif
    .ctx_clr (ctx_clr)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int ch;
    int hits;
    int cyc;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: per-channel history of the last three bits of that
  // channel's own stream; a hit is any 4-bit window equal to 1011.
  logic [2:0] hist[2];
  int         ecnt[2];
  int         busy;
  int         last_g;

  always @(negedge Clock) begin
    if (Reset) begin
      sb_q.delete();
      hist[0] = '0; hist[1] = '0;
      ecnt[0] = 0;  ecnt[1] = 0;
      busy = 0;
      last_g = 1;
    end else begin
      bit idle, v0, v1, r0, r1;
      idle = (busy == 0);
      if (!idle) busy--;
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      r0 = idle && v0 && (!v1 || last_g == 1);
      r1 = idle && v1 && (!v0 || last_g == 0);
      chk("req0_ready", int'(bus.req0_ready), int'(r0));
      chk("req1_ready", int'(bus.req1_ready), int'(r1));
      if (idle) begin
        for (int i = 0; i < 2; i++)
          if (ctx_clr[i]) begin hist[i] = '0; ecnt[i] = 0; end
        if (r0 || r1) begin
          int ch, n;
          logic [DW-1:0] d;
          logic [3:0] w;
          ch = r1 ? 1 : 0;
          d = r1 ? bus.req1_data : bus.req0_data;
          n = 0;
          for (int i = DW - 1; i >= 0; i--) begin
            w = {hist[ch], d[i]};
            if (w == 4'b1011) n++;
            hist[ch] = w[2:0];
          end
          ecnt[ch] = (ecnt[ch] + n > 65535) ? 65535 : ecnt[ch] + n;
          sb_q.push_back('{ch: ch, hits: n, cyc: cyc + DW + 2});
          last_g = ch;
          busy = DW + 2;
        end
      end
    end
  end

  // Monitor: every result pulse must match the oldest outstanding word
  always @(negedge Clock) begin
    if (!Reset && bus.res_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_res_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res_ch", int'(bus.res_ch), e.ch);
        chk("res_hits", int'(bus.res_hits), e.hits);
        chk("res_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input int ch, input logic [DW-1:0] d, input logic [1:0] clr);
    bit got;
    got = 0;
    if (ch == 0) begin bus.req0_valid = 1'b1; bus.req0_data = d; end
    else         begin bus.req1_valid = 1'b1; bus.req1_data = d; end
    ctx_clr = clr;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clock);
      got = (ch == 0) ? bus.req0_ready : bus.req1_ready;
    end
    chk("handshake_seen", int'(got), 1);
    @(posedge Clock); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    ctx_clr = 2'b00;
  endtask

  task automatic exp_res(input int ch, input int hits);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clock);
      got = bus.res_valid;
    end
    chk("directed_res_seen", int'(got), 1);
    if (got) begin
      chk("directed_res_ch", int'(bus.res_ch), ch);
      chk("directed_res_hits", int'(bus.res_hits), hits);
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    int seen;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hFF;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    repeat (2) @(negedge Clock);
    chk("rst_req0_ready", int'(bus.req0_ready), 0);
    chk("rst_req1_ready", int'(bus.req1_ready), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_res_ch", int'(bus.res_ch), 0);
    chk("rst_res_hits", int'(bus.res_hits), 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    bus.req0_valid = 1'b0;

    // Directed cases from a fresh reset
    send(0, 8'h0B, 2'b00); exp_res(0, 1);
    send(0, 8'hB6, 2'b00); exp_res(0, 2);
    send(0, 8'h05, 2'b00); exp_res(0, 0);
    send(1, 8'h00, 2'b00); exp_res(1, 0);
    send(0, 8'h80, 2'b00); exp_res(0, 1);
    send(0, 8'h05, 2'b00); exp_res(0, 0);
    send(0, 8'h80, 2'b01); exp_res(0, 0);

    // Both channels valid continuously from reset
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (400) begin
      bus.req0_data = DW'($urandom);
      bus.req1_data = DW'($urandom);
      @(posedge Clock); #1;
    end

    // Random valids, data and occasional context clears
    repeat (1500) begin
      bus.req0_valid = 1'($urandom);
      bus.req1_valid = 1'($urandom);
      bus.req0_data  = ($urandom_range(0, 3) == 0) ? 8'hB6 : DW'($urandom);
      bus.req1_data  = DW'($urandom);
      ctx_clr        = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      @(posedge Clock); #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    ctx_clr = 2'b00;
    repeat (15) @(posedge Clock);
    #1;
    chk("sb_drained_random", sb_q.size(), 0);

    // Reset in the middle of SHIFT aborts the word
    send(0, 8'h0B, 2'b00);
    repeat (4) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge Clock);
      if (bus.res_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    @(posedge Clock); #1;
    send(0, 8'h80, 2'b00); exp_res(0, 0);
`ifdef DET_HITCNT_EN
    @(negedge Clock);
    chk("hit_cnt0_after_abort", int'(hit_cnt0), 0);
`endif

    repeat (5) @(posedge Clock);
    #1;
    chk("sb_drained_final", sb_q.size(), 0);
`ifdef DET_HITCNT_EN
    chk("hit_cnt0_final", int'(hit_cnt0), ecnt[0]);
    chk("hit_cnt1_final", int'(hit_cnt1), ecnt[1]);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/det1011_arb2.md
# det1011_arb2

Two-channel round-robin scheduler that shares one serial 1011 Mealy detector between two byte-wide requesters. Each accepted word is restored into the detector with that channel's saved 2-bit detector context and shifted in MSB-first, one bit per clock. The block then saves the context back and reports the number of pattern hits found in that word. Channel streams stay independent: a pattern spanning two words of the same channel is detected even when the other channel is served in between.

## Interface
- DATA_W, 8, bits per request word
- HIT_W, $clog2(DATA_W+1), width of per-word hit count
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  channel 0 word offered
- req0_data  in  DATA_W  channel 0 word
- req0_ready  out  1  channel 0 word accepted this cycle
- req1_valid, req1_data, req1_ready  as channel 0, for channel 1
- res_valid  out  1  one-cycle result pulse
- res_ch  out  1  channel the result belongs to
- res_hits  out  HIT_W  hits detected in that word
- ctx_clr  in  2  per-channel context clear, bit i clears channel i context (only when IDLE)

## Operation
- Detector state b[1:0] follows these equations:
  - next b0 = x
  - next b1 = b0&~x | b1&~b0&x
  - hit y = b1&b0&x
- Hits overlap: 10110110 gives 2 hits.
- Contexts ctx0 and ctx1 are 2-bit registers. Their reset value is 00.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - **IDLE:** grant = winner among valid requesters. reqN_ready = 1 combinationally for the winner only. On handshake, capture the word into a shift register, latch grant, go to LOAD. If ctx_clr[i] is high in the same cycle, ctx i is cleared before the LOAD reads it.
  - **LOAD:** detector state is loaded from ctx[grant]. Bit counter is set to DATA_W-1. Hit accumulator is set to 0. Go to SHIFT.
  - **SHIFT:** each cycle, feed the MSB, shift left, and add y to the accumulator. After DATA_W bits go to DONE.
  - **DONE:** write detector state to ctx[grant]. Pulse res_valid with res_ch = grant and res_hits = accumulator. Go to IDLE.
- Round-robin rule:
  - Only one channel valid: that channel wins.
  - Both channels valid: the channel not served last wins.
  - last_grant resets to 1, so channel 0 wins the first tie.
- Both ready outputs are 0 outside IDLE. A valid that drops before the handshake is simply not served.
- ctx_clr is ignored outside IDLE.
- No backpressure on results. The consumer must accept res_valid in the cycle it is high.

## Timing
- Handshake at cycle T, then LOAD at T+1, SHIFT at T+2 to T+DATA_W+1, DONE at T+DATA_W+2.
- res_valid is high in cycle T+DATA_W+2 (T+10 for DATA_W=8), registered.
- Earliest next handshake: T+DATA_W+3. Throughput is one word per DATA_W+3 cycles.
- Reset values: req0_ready=0, req1_ready=0, res_valid=0, res_ch=0, res_hits=0, state IDLE, ctx0=ctx1=00, last_grant=1.
- Reset mid-operation aborts the word immediately. No result is produced and both contexts return to 00. Ready may assert in the first cycle after Reset deasserts.

## Configuration
- DET_HITCNT_EN defined:
  - Adds outputs hit_cnt0 and hit_cnt1, each 16 bits, reset value 0.
  - In DONE, hit_cnt[grant] += res_hits, saturating at 16'hFFFF.
  - ctx_clr[i] also clears hit_cnt i.
- DET_HITCNT_EN undefined: these ports and registers do not exist. All other behaviour is identical.

## Structure
- Package det_pkg holds:
  - FSM state enum: IDLE, LOAD, SHIFT, DONE.
  - Context typedef: logic [1:0].
  - Context reset constant: CTX_RST = 2'b00.
- Sub-module det1011_core holds the detector step:
  - Inputs: Clock, Reset, en, load, load_state[1:0], x.
  - Outputs: y, state[1:0].
  - load has priority over en.
  - y is combinational from state and x.
- Top-level det1011_arb2 holds the FSM, arbiter, shift register, bit counter, accumulator, contexts and optional counters.

## Test plan
- Fresh reset; ch0 sends 8'h0B with ch1 idle -> handshake at T; res_valid at T+10 with res_ch=0, res_hits=1.
- ch0 sends 8'hB6 -> res_hits=2 (overlapping hits).
- ch0 sends 8'h05, then ch1 sends 8'h00, then ch0 sends 8'h80 -> results in order are 0, 0, 1. Channel 0's context crosses the word boundary despite the interleaved ch1 word.
- Both valid continuously from reset -> grants alternate 0,1,0,1. Each ready pulses one cycle, 11 cycles apart.
- Cross-word case with clear: ch0 sends 8'h05; in IDLE ctx_clr=2'b01 together with ch0 sending 8'h80 -> res_hits=0.
- Reset asserted during SHIFT -> no res_valid. After release, ch0 sending 8'h80 gives res_hits=0 (context cleared). With DET_HITCNT_EN defined, hit_cnt0 also reads 0.
